// File: rtl/mux_scan_sequencer.sv
// Round-robin scan controller for a 4:1 mux: steps s through 0..3 and holds each
// channel DWELL cycles. It samples f per channel and hands out a 4-bit frame on valid/ready.
module mux_scan_sequencer #(
   parameter int unsigned DWELL = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       cont,
   input  logic       f,
   output logic [1:0] s,
   output logic       busy,
   output logic [3:0] q,
   output logic       q_valid,
   input  logic       q_ready,
   output logic [7:0] frame_cnt
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [7:0] LAST = 8'(DWELL - 1);

   state_t     state;
   logic [7:0] cnt;
   logic [2:0] shadow;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         s         <= '0;
         busy      <= 1'b0;
         q         <= '0;
         q_valid   <= 1'b0;
         frame_cnt <= '0;
         cnt       <= '0;
         shadow    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start | cont) begin
                  state <= SCAN;
                  s     <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            SCAN: begin
               if (cnt == LAST) begin
                  cnt <= '0;
                  if (s != 2'd3) begin
                     shadow[s] <= f;
                     s         <= s + 2'd1;
                  end else begin
                     // The last channel bypasses the shadow and goes straight into the frame.
                     q         <= {f, shadow};
                     q_valid   <= 1'b1;
                     frame_cnt <= frame_cnt + 8'd1;
                     s         <= '0;
                     busy      <= 1'b0;
                     state     <= DONE;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               if (q_valid && q_ready) begin
                  q_valid <= 1'b0;
                  if (cont | start) begin
                     state <= SCAN;
                     s     <= '0;
                     cnt   <= '0;
                     busy  <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: three instances (DWELL 2, 1, 3) each drive a behavioural mux.
// A negedge monitor checks every accepted frame against a per-instance queue of expected frames.
module tb_mux_scan_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start   [3];
   logic       cont    [3];
   logic       q_ready [3];
   logic [3:0] d       [3];
   logic       f       [3];
   logic [1:0] s       [3];
   logic       busy    [3];
   logic [3:0] q       [3];
   logic       q_valid [3];
   logic [7:0] frame_cnt [3];

   logic [3:0] expq [3][$];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mux_scan_sequencer #(.DWELL(2)) u0 (
      .clk(clk), .reset(reset), .start(start[0]), .cont(cont[0]), .f(f[0]), .s(s[0]),
      .busy(busy[0]), .q(q[0]), .q_valid(q_valid[0]), .q_ready(q_ready[0]),
      .frame_cnt(frame_cnt[0]));
   mux_scan_sequencer #(.DWELL(1)) u1 (
      .clk(clk), .reset(reset), .start(start[1]), .cont(cont[1]), .f(f[1]), .s(s[1]),
      .busy(busy[1]), .q(q[1]), .q_valid(q_valid[1]), .q_ready(q_ready[1]),
      .frame_cnt(frame_cnt[1]));
   mux_scan_sequencer #(.DWELL(3)) u2 (
      .clk(clk), .reset(reset), .start(start[2]), .cont(cont[2]), .f(f[2]), .s(s[2]),
      .busy(busy[2]), .q(q[2]), .q_valid(q_valid[2]), .q_ready(q_ready[2]),
      .frame_cnt(frame_cnt[2]));

   // Behavioural mux: f follows the currently selected data bit.
   assign f[0] = d[0][s[0]];
   assign f[1] = d[1][s[1]];
   assign f[2] = d[2][s[2]];

   always @(negedge clk) begin
      logic [3:0] e;
      for (int k = 0; k < 3; k++) begin
         if (!reset && q_valid[k] && q_ready[k]) begin
            total++;
            if (expq[k].size() == 0) begin
               bad++;
               $display("FAIL frame_u%0d unexpected frame q=%b required none", k, q[k]);
            end else begin
               e = expq[k].pop_front();
               if (q[k] !== e) begin
                  bad++;
                  $display("FAIL frame_u%0d q=%b required %b", k, q[k], e);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_idle_out(input int k, input string tag);
      chk({tag, "_s"}, int'(s[k]), 0);
      chk({tag, "_busy"}, int'(busy[k]), 0);
      chk({tag, "_q"}, int'(q[k]), 0);
      chk({tag, "_qvalid"}, int'(q_valid[k]), 0);
      chk({tag, "_framecnt"}, int'(frame_cnt[k]), 0);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         start[k] = 1'b0; cont[k] = 1'b0; q_ready[k] = 1'b1; d[k] = 4'b0000;
      end
      tick(1);
      for (int k = 0; k < 3; k++) chk_idle_out(k, $sformatf("reset_u%0d", k));
      reset = 1'b0;
      tick(2);

      // Single scan, DWELL=2, d=1010
      d[0] = 4'b1010;
      expq[0].push_back(4'b1010);
      start[0] = 1'b1;
      tick(1);
      start[0] = 1'b0;
      chk("t1_busy_e0", int'(busy[0]), 1);
      chk("t1_s_e0", int'(s[0]), 0);
      for (int t = 1; t < 8; t++) begin
         tick(1);
         chk($sformatf("t1_s_e%0d", t), int'(s[0]), t / 2);
         chk($sformatf("t1_qv_e%0d", t), int'(q_valid[0]), 0);
      end
      tick(1);
      chk("t1_qvalid", int'(q_valid[0]), 1);
      chk("t1_q", int'(q[0]), 4'b1010);
      chk("t1_busy_done", int'(busy[0]), 0);
      chk("t1_framecnt", int'(frame_cnt[0]), 1);
      tick(1);
      chk("t1_qvalid_after", int'(q_valid[0]), 0);
      tick(2);
      chk("t1_idle_busy", int'(busy[0]), 0);

      // Backpressure, DWELL=1, d=0110
      d[1] = 4'b0110;
      q_ready[1] = 1'b0;
      expq[1].push_back(4'b0110);
      start[1] = 1'b1;
      tick(1);
      start[1] = 1'b0;
      for (int t = 1; t < 4; t++) begin
         tick(1);
         chk($sformatf("t2_s_e%0d", t), int'(s[1]), t);
      end
      tick(1);
      chk("t2_qvalid", int'(q_valid[1]), 1);
      for (int t = 0; t < 5; t++) begin
         tick(1);
         chk("t2_hold_qvalid", int'(q_valid[1]), 1);
         chk("t2_hold_q", int'(q[1]), 4'b0110);
         chk("t2_hold_s", int'(s[1]), 0);
         chk("t2_hold_busy", int'(busy[1]), 0);
      end
      q_ready[1] = 1'b1;
      tick(1);
      chk("t2_accept_qvalid", int'(q_valid[1]), 0);
      chk("t2_accept_busy", int'(busy[1]), 0);
      chk("t2_framecnt", int'(frame_cnt[1]), 1);

      // Continuous mode, DWELL=1, frames 0001 then 1000
      d[1] = 4'b0001;
      expq[1].push_back(4'b0001);
      cont[1] = 1'b1;
      tick(1);
      tick(4);
      chk("t3_f1_qvalid", int'(q_valid[1]), 1);
      chk("t3_f1_framecnt", int'(frame_cnt[1]), 2);
      d[1] = 4'b1000;
      expq[1].push_back(4'b1000);
      tick(1);
      chk("t3_f1_drop", int'(q_valid[1]), 0);
      chk("t3_rescan_busy", int'(busy[1]), 1);
      cont[1] = 1'b0;
      tick(3);
      chk("t3_gap_qvalid", int'(q_valid[1]), 0);
      tick(1);
      chk("t3_f2_qvalid", int'(q_valid[1]), 1);
      chk("t3_f2_framecnt", int'(frame_cnt[1]), 3);
      tick(1);
      chk("t3_f2_drop", int'(q_valid[1]), 0);
      tick(3);
      chk("t3_stop_busy", int'(busy[1]), 0);
      chk("t3_stop_qvalid", int'(q_valid[1]), 0);

      // Reset mid-scan, DWELL=3
      d[2] = 4'b1101;
      expq[2].push_back(4'b1101);
      start[2] = 1'b1;
      tick(1);
      start[2] = 1'b0;
      tick(12);
      chk("t4_f1_qvalid", int'(q_valid[2]), 1);
      chk("t4_f1_q", int'(q[2]), 4'b1101);
      tick(1);
      start[2] = 1'b1;
      tick(1);
      start[2] = 1'b0;
      tick(6);
      chk("t4_s_before_reset", int'(s[2]), 2);
      chk("t4_busy_before_reset", int'(busy[2]), 1);
      #2 reset = 1'b1;
      #1;
      chk_idle_out(2, "t4_async");
      @(posedge clk);
      #1 reset = 1'b0;
      tick(20);
      chk("t4_no_frame_qvalid", int'(q_valid[2]), 0);
      chk("t4_no_frame_busy", int'(busy[2]), 0);
      chk("t4_no_frame_cnt", int'(frame_cnt[2]), 0);

      // start held through SCAN and DONE, DWELL=2
      q_ready[0] = 1'b0;
      expq[0].push_back(4'b1010);
      start[0] = 1'b1;
      tick(9);
      chk("t5_qvalid", int'(q_valid[0]), 1);
      chk("t5_framecnt", int'(frame_cnt[0]), 1);
      for (int t = 0; t < 4; t++) begin
         tick(1);
         chk("t5_stall_qvalid", int'(q_valid[0]), 1);
         chk("t5_stall_busy", int'(busy[0]), 0);
         chk("t5_stall_framecnt", int'(frame_cnt[0]), 1);
      end
      q_ready[0] = 1'b1;
      expq[0].push_back(4'b1010);
      tick(1);
      start[0] = 1'b0;
      chk("t5_restart_busy", int'(busy[0]), 1);
      chk("t5_restart_qvalid", int'(q_valid[0]), 0);
      tick(8);
      chk("t5_f2_qvalid", int'(q_valid[0]), 1);
      chk("t5_f2_framecnt", int'(frame_cnt[0]), 2);
      tick(1);
      chk("t5_f2_drop", int'(q_valid[0]), 0);

      // 256 continuous frames, DWELL=1, frame_cnt wraps to 0
      d[1] = 4'b0011;
      expq[1].push_back(4'b0011);
      cont[1] = 1'b1;
      tick(1);
      for (int k = 0; k < 256; k++) begin
         tick(4);
         chk("t6_qvalid", int'(q_valid[1]), 1);
         chk($sformatf("t6_framecnt_%0d", k), int'(frame_cnt[1]), (k + 1) % 256);
         if (k < 255) begin
            d[1] = 4'((k * 7 + 5) % 16);
            expq[1].push_back(d[1]);
         end else begin
            cont[1] = 1'b0;
         end
         tick(1);
         chk("t6_pulse", int'(q_valid[1]), 0);
      end
      tick(2);
      chk("t6_end_busy", int'(busy[1]), 0);
      chk("t6_end_framecnt", int'(frame_cnt[1]), 0);

      tick(2);
      for (int k = 0; k < 3; k++) chk($sformatf("pending_u%0d", k), expq[k].size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
